// File: rtl/lsu_bus_ctrl.sv
// lsu_bus_ctrl
// MEM-stage load/store bus controller. Issues one SRAM-like bus transaction
// at a time, builds byte strobes and lane-replicated store data, flags
// misaligned accesses, stalls the pipeline until the access completes and
// latches the raw read word for the load-extension stage.
//
// Ports
//   clk, reset                   clock, async active-high reset
//   req_valid/we/size/addr/wdata MEM-stage access (held while mem_stall=1)
//   flush                        squash of the MEM-stage instruction
//   stage_advance                MEM hands its instruction to WB
//   data_req/wr/size/addr/wstrb/wdata  bus request fields
//   data_addr_ok, data_data_ok, data_rdata  bus handshake / read word
//   mem_stall                    hold the pipeline
//   p_data_rdata, rdata_valid    latched read word and its validity
//   addr_err                     misaligned access (AdEL/AdES upstream)
//
// state | meaning
// IDLE  | no transaction; accepts a new aligned access
// REQ   | data_req high, waiting for data_addr_ok
// WAIT  | address accepted, waiting for data_data_ok
// DONE  | access complete, result held until the stage advances
// DRAIN | squashed access in flight; swallow its response

module lsu_bus_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        flush,
    input  logic        stage_advance,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic        mem_stall,
    output logic [31:0] p_data_rdata,
    output logic        rdata_valid,
    output logic        addr_err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t      state, state_nxt;
    logic        cancel;
    logic        aligned;
    logic        start;
    logic [3:0]  wstrb_nxt;
    logic [31:0] wdata_nxt;

    always_comb begin
        case (req_size)
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~req_addr[0];
            default: aligned = (req_addr[1:0] == 2'b00);
        endcase
    end

    assign start = (state == S_IDLE) & req_valid & aligned & ~flush;

    always_comb begin
        wstrb_nxt = 4'b1111;
        wdata_nxt = req_wdata;
        case (req_size)
            2'b00: begin
                wstrb_nxt = 4'b0001 << req_addr[1:0];
                wdata_nxt = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                wstrb_nxt = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_nxt = {2{req_wdata[15:0]}};
            end
            default: begin
                wstrb_nxt = 4'b1111;
                wdata_nxt = req_wdata;
            end
        endcase
        if (!req_we) begin
            wstrb_nxt = 4'b0000;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_REQ;
            end
            S_REQ: begin
                // A flush seen while the request is pending (now or earlier)
                // must still let the bus finish, so it goes to DRAIN.
                if (data_addr_ok) state_nxt = (cancel | flush) ? S_DRAIN : S_WAIT;
            end
            S_WAIT: begin
                if (flush && data_data_ok) state_nxt = S_IDLE;
                else if (flush)            state_nxt = S_DRAIN;
                else if (data_data_ok)     state_nxt = S_DONE;
            end
            S_DONE: begin
                if (stage_advance || flush) state_nxt = S_IDLE;
            end
            S_DRAIN: begin
                if (data_data_ok) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        data_req    = (state == S_REQ);
        rdata_valid = (state == S_DONE) & ~data_wr;
        addr_err    = (state == S_IDLE) & req_valid & ~aligned;
        mem_stall   = start | (state == S_REQ) | (state == S_WAIT)
                    | ((state == S_DRAIN) & req_valid);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_wr      <= 1'b0;
            data_size    <= 2'b00;
            data_addr    <= 32'h0;
            data_wstrb   <= 4'b0000;
            data_wdata   <= 32'h0;
            p_data_rdata <= 32'h0;
            cancel       <= 1'b0;
        end else begin
            if (start) begin
                data_wr    <= req_we;
                data_size  <= req_size;
                data_addr  <= req_addr;
                data_wstrb <= wstrb_nxt;
                data_wdata <= wdata_nxt;
            end
            if (state == S_REQ) begin
                if (data_addr_ok) cancel <= 1'b0;
                else if (flush)   cancel <= 1'b1;
            end
            if (state == S_WAIT && data_data_ok && !flush && !data_wr) begin
                p_data_rdata <= data_rdata;
            end
        end
    end

endmodule

// File: doc/lsu_bus_ctrl.md
# lsu_bus_ctrl

Load/store bus controller for the MEM stage. It turns the pipeline's memory access (address, size, store data) into a single-outstanding SRAM-like bus transaction, generates byte strobes and lane-replicated store data, and checks alignment. It stalls the pipeline until the transaction completes. It latches the raw 32-bit read word as `p_data_rdata`, which feeds the downstream load-extension stage.

## Interface

- No parameters.
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; returns every register to its reset value immediately.
- `req_valid` in 1: MEM stage holds a load or store; held stable with the other `req_*` inputs while `mem_stall`=1.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word; 11 is treated as word.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `flush` in 1: exception/ERET squash of the MEM-stage instruction.
- `stage_advance` in 1: MEM stage hands its instruction to WB this cycle.
- `data_req` out 1: bus request.
- `data_wr` out 1: bus write.
- `data_size` out 2: equals the registered `req_size`.
- `data_addr` out 32: registered byte address.
- `data_wstrb` out 4: byte enables; 0000 on loads.
- `data_wdata` out 32: lane-replicated store data.
- `data_addr_ok` in 1: address accepted.
- `data_data_ok` in 1: read data valid / write complete.
- `data_rdata` in 32: read word.
- `mem_stall` out 1: hold the pipeline.
- `p_data_rdata` out 32: latched raw read word for load extension.
- `rdata_valid` out 1: `p_data_rdata` belongs to the current MEM instruction.
- `addr_err` out 1: misaligned access; the instruction raises AdEL (load) or AdES (store) upstream.

## Operation

- States: IDLE, REQ, WAIT, DONE, DRAIN. Reset state is IDLE.
- Reset values: `data_req`=0, `data_wr`=0, `data_size`=00, `data_addr`=0, `data_wstrb`=0000, `data_wdata`=0, `p_data_rdata`=0, `rdata_valid`=0, `addr_err`=0, `mem_stall`=0.
- Misaligned access: half with `addr[0]`=1, or word with `addr[1:0]`≠00.
- `addr_err` is combinational: asserted only in IDLE, when `req_valid`=1 and the access is misaligned. A misaligned access never issues a bus request and never stalls.
- IDLE → REQ when `req_valid` is set, the access is aligned, and `flush`=0. On this transition, register the bus fields:
  - `data_addr`=`req_addr`.
  - `data_wr`=`req_we`.
  - `data_size`=`req_size`.
  - `data_wstrb`: byte → 0001<<`addr[1:0]`; half → `addr[1]` ? 1100 : 0011; word → 1111; all cases AND `req_we`.
  - `data_wdata`: byte → {4{wdata[7:0]}}; half → {2{wdata[15:0]}}; word → wdata.
- REQ: `data_req`=1. On `data_addr_ok`, go to WAIT, or to DRAIN if a flush was recorded (a flush in REQ sets a cancel flag). The request is never withdrawn before `data_addr_ok`.
- WAIT: on `data_data_ok`, capture `data_rdata` into `p_data_rdata` (loads only; stores leave it unchanged) and go to DONE. `flush` in WAIT goes to DRAIN. If `flush` and `data_data_ok` arrive together, go to IDLE and discard the data.
- DONE: `rdata_valid`=1 for loads, `mem_stall`=0. Go to IDLE on `stage_advance` or `flush`; otherwise hold.
- DRAIN: wait for `data_data_ok`, discard it, go to IDLE. No new request is issued in DRAIN.
- `mem_stall` = (IDLE & `req_valid` & aligned & !`flush`) | REQ | WAIT | (DRAIN & `req_valid`).
- At most one outstanding transaction. `data_data_ok` in IDLE, REQ, or DONE is ignored.

## Timing

- Cycle 0: IDLE sees a request. Cycle 1: REQ with `data_req`=1.
- With `data_addr_ok` in cycle 1 and `data_data_ok` in cycle n ≥ 2: DONE is reached in cycle n+1, with `p_data_rdata` valid and `mem_stall` low. Minimum load latency is 3 cycles from request to unstall.
- `data_data_ok` is never earlier than the cycle after `data_addr_ok`.
- Bus outputs are stable from REQ until `data_addr_ok` inclusive.
- Reset asserted mid-transaction forces IDLE immediately. The bus response that follows is not tracked; the SoC resets the bus slave together with the core.

## Test plan

- Aligned word load, addr 0x1000_0004, `addr_ok` in cycle 1, `data_ok` in cycle 3 with rdata 0xDEAD_BEEF → `data_req`=1 only in cycle 1; `p_data_rdata`=0xDEAD_BEEF and `rdata_valid`=1 in cycle 4; `mem_stall` high in cycles 0–3.
- Byte store, addr offset 2, wdata 0x0000_00A5 → `data_wstrb`=0100, `data_wdata`=0xA5A5_A5A5, `data_wr`=1. Half store, offset 2, wdata 0x1234 → `data_wstrb`=1100, `data_wdata`=0x1234_1234.
- Half load at offset 1, and word store at offset 2 → `addr_err`=1, `data_req` never asserted, `mem_stall`=0.
- `addr_ok` delayed 3 cycles → `data_req` and `data_addr` held constant throughout; `flush` during REQ → DRAIN after `addr_ok`, response swallowed, `rdata_valid` stays 0.
- `flush` and `data_data_ok` in the same WAIT cycle → IDLE next cycle, `p_data_rdata` unchanged.
- DONE held for 2 cycles with `stage_advance`=0 → `p_data_rdata` stable, no new `data_req`; after `stage_advance`, a back-to-back load issues REQ two cycles later.
